bram_loader: RTL

BRAM_LOADER -- requirements
Module: bram_loader

---
 rtl/bram_loader.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/bram_loader.sv
`default_nettype none
// ============================================================================
//  Module   : bram_loader
//  Purpose  : Streams a requested number of words from a valid/ready source
//             into consecutive BRAM addresses starting at 0.
//             - A load request (start + length) is taken only in IDLE.
//             - The length is clamped to the BRAM capacity.
//             - The BRAM write follows each accepted word by exactly one cycle.
//             - abort ends a load early without a done pulse.
//  Ports    : clock     - single clock, rising edge
//             reset     - asynchronous, active-high
//             start     - one-cycle load request (IDLE only)
//             length    - words to load, sampled with start
//             abort     - terminates an active load
//             in_data   - stream word
//             in_valid  - stream word valid
//             in_ready  - loader accepts a word this cycle
//             mem_we    - BRAM write enable
//             mem_addr  - BRAM write address
//             mem_wdata - BRAM write data
//             busy      - high while loading or completing
//             done      - one-cycle completion pulse
//             count     - words written in the current/last load
//  Revision : 1.0  initial release
// ============================================================================
module bram_loader #(
    parameter int ID         = 1,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH:0]   count
);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_LOAD = 2'd1;
    localparam logic [1:0] c_S_DONE = 2'd2;

    // Capacity is 2**ADDR_WIDTH, which needs the extra top bit of length/count.
    localparam logic [ADDR_WIDTH:0]   c_CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0]   c_CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] c_ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]            r_state;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_ready;
    logic                  w_accept;
    logic [ADDR_WIDTH:0]   w_len_clamped;
    logic [ADDR_WIDTH:0]   w_count_next;

    // abort blocks acceptance in the same cycle, so an aborted cycle never writes.
    assign w_ready       = (r_state == c_S_LOAD) && !abort;
    assign w_accept      = w_ready && in_valid;
    assign w_len_clamped = (length > c_CAPACITY) ? c_CAPACITY : length;
    assign w_count_next  = r_count + c_CNT_ONE;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= c_S_IDLE;
            r_len       <= '0;
            r_addr      <= '0;
            r_count     <= '0;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // Write port: one-cycle delayed copy of each accepted word. This
            // runs independently of the state so a write pending from the
            // last accepted word still completes after DONE or abort.
            r_we <= w_accept;
            if (w_accept) begin
                r_mem_addr  <= r_addr;
                r_mem_wdata <= in_data;
            end

            case (r_state)
                c_S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_len   <= w_len_clamped;
                        r_count <= '0;
                        r_addr  <= '0;
                        r_busy  <= 1'b1;
                        if (w_len_clamped != '0) begin
                            r_state <= c_S_LOAD;
                        end else begin
                            r_state <= c_S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                c_S_LOAD: begin
                    if (abort) begin
                        r_state <= c_S_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_accept) begin
                        // Address wraps naturally; only reached after the
                        // final word of a full-capacity load.
                        r_addr  <= r_addr + c_ADDR_ONE;
                        r_count <= w_count_next;
                        if (w_count_next == r_len) begin
                            r_state <= c_S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end

                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= c_S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = w_ready;
    assign mem_we    = r_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign done      = r_done;
    assign count     = r_count;

endmodule
`default_nettype wire
